// File: rtl/dpram_pkg.sv
// Shared types and constants for the byte-enabled, pipelined dual-port RAM.
package dpram_pkg;

    typedef enum logic {WRITE_FIRST, READ_FIRST} collision_e;
    typedef enum logic {CLEAR, READY} state_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/dpram_clear_fsm.sv
// Clear engine: walks every address once after reset or on a clear request,
// holding off normal traffic while it runs.
module dpram_clear_fsm
    import dpram_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              init_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_e            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // A clear request while already clearing is ignored, so only READY looks at it.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == '1) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (clear) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
        endcase
    end

    assign init_busy = rst | (state_reg == CLEAR);
    assign clr_we    = ~rst & (state_reg == CLEAR);
    assign clr_addr  = cnt_reg;

endmodule

// File: rtl/dpram_be_pipe.sv
// Parametrised dual-port RAM with byte enables, 1- or 2-cycle read pipeline,
// selectable same-address collision policy and a hardware clear engine.
module dpram_be_pipe
    import dpram_pkg::*;
#(
    parameter int         DATA_W    = 16,
    parameter int         ADDR_W    = 8,
    parameter int         RD_LAT    = 1,
    parameter collision_e COLLISION = WRITE_FIRST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        wr_address,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    input  logic                     read,
    input  logic [ADDR_W-1:0]        rd_address,
    output logic [DATA_W-1:0]        data_out,
    output logic                     rd_valid,
    input  logic                     clear,
    output logic                     init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / BYTE_W;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("dpram_be_pipe: RD_LAT must be 1 or 2");
    end
    if (DATA_W % BYTE_W != 0) begin : g_bad_data_w
        $error("dpram_be_pipe: DATA_W must be a multiple of 8");
    end

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    dpram_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    logic wr_acc, rd_acc;
    assign wr_acc = write & ~init_busy;
    assign rd_acc = read & ~init_busy;

    // Clear writes and user writes never overlap, so one shared write port suffices.
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_we;
    assign mem_waddr = clr_we ? clr_addr : wr_address;
    assign mem_wdata = clr_we ? '0 : data_in;
    assign mem_we    = clr_we ? {NB{1'b1}} : (wr_acc ? wr_be : {NB{1'b0}});

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_we[b]) begin
                mem[mem_waddr][b*BYTE_W +: BYTE_W] <= mem_wdata[b*BYTE_W +: BYTE_W];
            end
        end
    end

    // Write-first bypass: lanes being written this cycle come from data_in.
    logic [DATA_W-1:0] rd_word, rd_merge, rd_sel;
    logic              same_addr;
    assign rd_word   = mem[rd_address];
    assign same_addr = wr_acc && (wr_address == rd_address);

    genvar gi;
    for (gi = 0; gi < NB; gi++) begin : g_merge
        assign rd_merge[gi*BYTE_W +: BYTE_W] = (same_addr && wr_be[gi])
                                             ? data_in[gi*BYTE_W +: BYTE_W]
                                             : rd_word[gi*BYTE_W +: BYTE_W];
    end

    assign rd_sel = (COLLISION == WRITE_FIRST) ? rd_merge : rd_word;

    logic [DATA_W-1:0] s1_data_reg;
    logic              s1_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_reg  <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= rd_acc;
            if (rd_acc) begin
                s1_data_reg <= rd_sel;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] s2_data_reg;
        logic              s2_valid_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_data_reg  <= '0;
                s2_valid_reg <= 1'b0;
            end else begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_data_reg <= s1_data_reg;
                end
            end
        end

        assign data_out = s2_data_reg;
        assign rd_valid = s2_valid_reg;
    end else begin : g_lat1
        assign data_out = s1_data_reg;
        assign rd_valid = s1_valid_reg;
    end

endmodule

// File: tb/tb_dpram_be_pipe.sv
// Bench for dpram_be_pipe: two instances (1-cycle write-first, 2-cycle read-first)
// share one stimulus stream and are checked against a behavioural memory model.
module tb_dpram_be_pipe;
    import dpram_pkg::*;

    logic        clk;
    logic        rst, write, read, clear;
    logic [7:0]  wr_address, rd_address;
    logic [15:0] data_in;
    logic [1:0]  wr_be;
    logic [15:0] data_out1, data_out2;
    logic        rd_valid1, rd_valid2, init_busy1, init_busy2;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dpram_be_pipe #(
        .DATA_W (16), .ADDR_W (8), .RD_LAT (1), .COLLISION (WRITE_FIRST)
    ) dut1 (
        .clk (clk), .rst (rst), .write (write), .wr_address (wr_address),
        .data_in (data_in), .wr_be (wr_be), .read (read), .rd_address (rd_address),
        .data_out (data_out1), .rd_valid (rd_valid1), .clear (clear),
        .init_busy (init_busy1)
    );

    dpram_be_pipe #(
        .DATA_W (16), .ADDR_W (8), .RD_LAT (2), .COLLISION (READ_FIRST)
    ) dut2 (
        .clk (clk), .rst (rst), .write (write), .wr_address (wr_address),
        .data_in (data_in), .wr_be (wr_be), .read (read), .rd_address (rd_address),
        .data_out (data_out2), .rd_valid (rd_valid2), .clear (clear),
        .init_busy (init_busy2)
    );

    // Behavioural model: array contents, clear progress, and per-latency results.
    bit [15:0] mm [256];
    bit        m_clearing;
    int        m_cnt;
    bit        m_v1, m_s1v, m_v2;
    bit [15:0] m_d1, m_s1d, m_d2;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit [15:0] old_w, wf_w;
        bit        racc, wacc;
        if (rst) begin
            m_clearing = 1'b1;
            m_cnt      = 0;
            m_v1 = 1'b0; m_s1v = 1'b0; m_v2 = 1'b0;
            m_d1 = '0;   m_d2 = '0;
            return;
        end
        racc  = read && !m_clearing;
        wacc  = write && !m_clearing;
        old_w = mm[rd_address];
        wf_w  = old_w;
        if (wacc && wr_address == rd_address) begin
            for (int b = 0; b < 2; b++)
                if (wr_be[b]) wf_w[8*b +: 8] = data_in[8*b +: 8];
        end
        if (wacc) begin
            for (int b = 0; b < 2; b++)
                if (wr_be[b]) mm[wr_address][8*b +: 8] = data_in[8*b +: 8];
        end
        m_v2 = m_s1v;
        if (m_s1v) m_d2 = m_s1d;
        m_s1v = racc;
        if (racc) m_s1d = old_w;
        m_v1 = racc;
        if (racc) m_d1 = wf_w;
        if (m_clearing) begin
            mm[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 256) m_clearing = 1'b0;
        end else if (clear) begin
            m_clearing = 1'b1;
            m_cnt      = 0;
        end
    endtask

    // One clock: the model consumes the current inputs, then outputs are checked at negedge.
    task automatic tick();
        model_step();
        @(negedge clk);
        chk("busy1", 16'(init_busy1), 16'(m_clearing));
        chk("busy2", 16'(init_busy2), 16'(m_clearing));
        chk("valid1", 16'(rd_valid1), 16'(m_v1));
        chk("valid2", 16'(rd_valid2), 16'(m_v2));
        chk("dout1", data_out1, m_d1);
        chk("dout2", data_out2, m_d2);
    endtask

    task automatic idle();
        write = 1'b0; read = 1'b0; clear = 1'b0;
        wr_address = '0; rd_address = '0; data_in = '0; wr_be = '0;
    endtask

    task automatic wait_ready(input int already, output int n);
        n = already;
        while (init_busy1 && n < 400) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        bit        wr;
        bit [7:0]  wa;
        bit [15:0] din;
        bit [1:0]  be;
        bit        rd;
        bit [7:0]  ra;
        bit        v1;
        bit [15:0] d1;
        bit        v2;
        bit [15:0] d2;
    } vec_t;

    function automatic vec_t mk(bit wr, bit [7:0] wa, bit [15:0] din, bit [1:0] be,
                                bit rd, bit [7:0] ra, bit v1, bit [15:0] d1,
                                bit v2, bit [15:0] d2);
        vec_t v;
        v.wr = wr; v.wa = wa; v.din = din; v.be = be; v.rd = rd; v.ra = ra;
        v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2;
        return v;
    endfunction

    localparam int NV = 21;
    vec_t vt [NV];

    initial begin
        int n;
        // Expected outputs are those seen after the row's clock edge.
        vt[0]  = mk(0, 8'h00, 16'h0000, 2'b00, 1, 8'h00, 1, 16'h0000, 0, 16'h0000);
        vt[1]  = mk(0, 8'h00, 16'h0000, 2'b00, 1, 8'h7F, 1, 16'h0000, 1, 16'h0000);
        vt[2]  = mk(0, 8'h00, 16'h0000, 2'b00, 1, 8'hFF, 1, 16'h0000, 1, 16'h0000);
        vt[3]  = mk(1, 8'h10, 16'hABCD, 2'b11, 0, 8'h00, 0, 16'h0000, 1, 16'h0000);
        vt[4]  = mk(1, 8'h10, 16'h1234, 2'b01, 0, 8'h00, 0, 16'h0000, 0, 16'h0000);
        vt[5]  = mk(0, 8'h00, 16'h0000, 2'b00, 1, 8'h10, 1, 16'hAB34, 0, 16'h0000);
        vt[6]  = mk(1, 8'h20, 16'h5555, 2'b11, 0, 8'h00, 0, 16'hAB34, 1, 16'hAB34);
        vt[7]  = mk(1, 8'h20, 16'hAAAA, 2'b11, 1, 8'h20, 1, 16'hAAAA, 0, 16'hAB34);
        vt[8]  = mk(0, 8'h00, 16'h0000, 2'b00, 1, 8'h20, 1, 16'hAAAA, 1, 16'h5555);
        vt[9]  = mk(1, 8'h01, 16'h0101, 2'b11, 0, 8'h00, 0, 16'hAAAA, 1, 16'hAAAA);
        vt[10] = mk(1, 8'h02, 16'h0202, 2'b11, 0, 8'h00, 0, 16'hAAAA, 0, 16'hAAAA);
        vt[11] = mk(1, 8'h03, 16'h0303, 2'b11, 0, 8'h00, 0, 16'hAAAA, 0, 16'hAAAA);
        vt[12] = mk(0, 8'h00, 16'h0000, 2'b00, 1, 8'h01, 1, 16'h0101, 0, 16'hAAAA);
        vt[13] = mk(0, 8'h00, 16'h0000, 2'b00, 1, 8'h02, 1, 16'h0202, 1, 16'h0101);
        vt[14] = mk(0, 8'h00, 16'h0000, 2'b00, 1, 8'h03, 1, 16'h0303, 1, 16'h0202);
        vt[15] = mk(0, 8'h00, 16'h0000, 2'b00, 0, 8'h00, 0, 16'h0303, 1, 16'h0303);
        vt[16] = mk(1, 8'h10, 16'hFFFF, 2'b00, 0, 8'h00, 0, 16'h0303, 0, 16'h0303);
        vt[17] = mk(0, 8'h00, 16'h0000, 2'b00, 1, 8'h10, 1, 16'hAB34, 0, 16'h0303);
        vt[18] = mk(1, 8'h10, 16'h5A00, 2'b10, 0, 8'h00, 0, 16'hAB34, 1, 16'hAB34);
        vt[19] = mk(0, 8'h00, 16'h0000, 2'b00, 1, 8'h10, 1, 16'h5A34, 0, 16'hAB34);
        vt[20] = mk(0, 8'h00, 16'h0000, 2'b00, 0, 8'h00, 0, 16'h5A34, 1, 16'h5A34);

        idle();
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_dout1", data_out1, 16'h0000);
        chk("reset_valid2", 16'(rd_valid2), 16'h0000);
        rst = 1'b0;
        wait_ready(0, n);
        chk("init_clear_len", 16'(n), 16'd256);

        for (int i = 0; i < NV; i++) begin
            write = vt[i].wr; wr_address = vt[i].wa; data_in = vt[i].din; wr_be = vt[i].be;
            read  = vt[i].rd; rd_address = vt[i].ra;
            tick();
            chk($sformatf("vec%0d_v1", i), 16'(rd_valid1), 16'(vt[i].v1));
            chk($sformatf("vec%0d_d1", i), data_out1, vt[i].d1);
            chk($sformatf("vec%0d_v2", i), 16'(rd_valid2), 16'(vt[i].v2));
            chk($sformatf("vec%0d_d2", i), data_out2, vt[i].d2);
        end

        // Reset with a read still in the 2-stage pipeline drops it.
        idle(); read = 1'b1; rd_address = 8'h10; tick();
        idle(); rst = 1'b1; tick();
        chk("rst_inflight_v2", 16'(rd_valid2), 16'h0000);
        chk("rst_dout1", data_out1, 16'h0000);
        chk("rst_dout2", data_out2, 16'h0000);
        tick();
        rst = 1'b0;
        wait_ready(0, n);
        chk("rst_clear_len", 16'(n), 16'd256);

        // Clear request; the same-cycle read is serviced, strobes while busy are not.
        idle(); write = 1'b1; wr_address = 8'h05; data_in = 16'hFFFF; wr_be = 2'b11; tick();
        idle(); clear = 1'b1; read = 1'b1; rd_address = 8'h05; tick();
        chk("clr_cycle_v1", 16'(rd_valid1), 16'h0001);
        chk("clr_cycle_d1", data_out1, 16'hFFFF);
        idle(); write = 1'b1; wr_address = 8'h06; data_in = 16'h1234; wr_be = 2'b11;
        read = 1'b1; rd_address = 8'h06; clear = 1'b1;
        tick();
        chk("busy_read_v1", 16'(rd_valid1), 16'h0000);
        wait_ready(1, n);
        chk("req_clear_len", 16'(n), 16'd256);
        idle(); read = 1'b1; rd_address = 8'h05; tick();
        chk("clr_05_d1", data_out1, 16'h0000);
        idle(); read = 1'b1; rd_address = 8'h06; tick();
        chk("clr_06_d1", data_out1, 16'h0000);
        chk("clr_06_v1", 16'(rd_valid1), 16'h0001);
        idle(); tick();

        // Reset at clear count 100 restarts the full clear and zeroes data_out.
        idle(); write = 1'b1; wr_address = 8'h03; data_in = 16'h0303; wr_be = 2'b11; tick();
        idle(); read = 1'b1; rd_address = 8'h03; tick();
        idle(); tick();
        chk("pre_rst_d2", data_out2, 16'h0303);
        idle(); clear = 1'b1; tick();
        idle(); repeat (100) tick();
        rst = 1'b1; read = 1'b1; rd_address = 8'h03;
        repeat (2) tick();
        chk("midclr_dout1", data_out1, 16'h0000);
        chk("midclr_dout2", data_out2, 16'h0000);
        idle(); rst = 1'b0;
        wait_ready(0, n);
        chk("midclr_len", 16'(n), 16'd256);

        // Randomised traffic on a narrow address window to provoke collisions.
        for (int i = 0; i < 1500; i++) begin
            write      = 1'($urandom_range(0, 1));
            wr_address = 8'($urandom_range(0, 15));
            data_in    = 16'($urandom);
            wr_be      = 2'($urandom_range(0, 3));
            read       = 1'($urandom_range(0, 1));
            rd_address = 8'($urandom_range(0, 15));
            clear      = ($urandom_range(0, 399) == 0);
            tick();
        end
        idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
